// File: rtl/highlight_arbiter_pkg.sv
// Shared encodings and sizes for the product-highlight arbiter.
package highlight_arbiter_pkg;

  localparam int NUM_PRODUCTS = 12;
  localparam int ID_W         = 4;
  localparam int NUM_ID_SRCS  = 2;  // interactive (0), basket (1)

  // State encoding doubles as the ActiveSource output code.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BARCODE     = 2'd1,
    INTERACTIVE = 2'd2,
    BASKET      = 2'd3
  } state_t;

endpackage

// File: rtl/highlight_arbiter_onehot.sv
// product_id_onehot: product ID + valid -> one-hot highlight, zero when
// the ID is out of range (>= NUM_PRODUCTS) or not valid.
module product_id_onehot
  import highlight_arbiter_pkg::*;
(
  input  logic [ID_W-1:0]         id,
  input  logic                    valid,
  output logic [NUM_PRODUCTS-1:0] onehot
);

  localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(NUM_PRODUCTS);

  // Decode one bit; anything outside the product range stays dark.
  always_comb begin
    onehot = '0;
    if (valid && (id < ID_LIMIT)) onehot[id] = 1'b1;
  end

endmodule

// File: rtl/highlight_arbiter.sv
// highlight_arbiter: fixed-priority arbiter (INTERACTIVE > BASKET > BARCODE)
// with minimum grant hold, ID decode and frame-synchronous highlight update.
// Optional feature macro: HIGHLIGHT_BLINK_EN (basket highlight blinks).
module highlight_arbiter
  import highlight_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_HALF  = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    BarcodeReq,
  input  logic [NUM_PRODUCTS-1:0] BarcodeMask,
  input  logic                    InteractiveReq,
  input  logic [ID_W-1:0]         InteractiveID,
  input  logic                    BasketReq,
  input  logic [ID_W-1:0]         BasketID,
  input  logic                    ValidID,
  input  logic                    FrameStart,
  output logic [NUM_PRODUCTS-1:0] HighlightedProductList,
  output logic [1:0]              ActiveSource,
  output logic                    BlinkPhase
);

  localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_PRODUCTS-1:0] src_data;
  logic [NUM_PRODUCTS-1:0] staged_q;

  // ID decode, one lane per ID-based source.
  logic [NUM_ID_SRCS-1:0][ID_W-1:0]         ids;
  logic [NUM_ID_SRCS-1:0][NUM_PRODUCTS-1:0] onehot;

  assign ids = {BasketID, InteractiveID};

  for (genvar g = 0; g < NUM_ID_SRCS; g++) begin : g_dec
    product_id_onehot u_onehot (
      .id     (ids[g]),
      .valid  (ValidID),
      .onehot (onehot[g])
    );
  end

  // Arbitration state and hold counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state: own-req drop always releases; preemption only by a
  // higher-priority requester once the hold counter has run out.
  always_comb begin
    state_d = state_q;
    hold_d  = (hold_q == '0) ? '0 : hold_q - 1'b1;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (InteractiveReq) begin
          state_d = INTERACTIVE;
          hold_d  = HOLD_LOAD;
        end else if (BasketReq) begin
          state_d = BASKET;
          hold_d  = HOLD_LOAD;
        end else if (BarcodeReq) begin
          state_d = BARCODE;
          hold_d  = HOLD_LOAD;
        end
      end
      BARCODE: begin
        if (!BarcodeReq) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if ((hold_q == '0) && InteractiveReq) begin
          state_d = INTERACTIVE;
          hold_d  = HOLD_LOAD;
        end else if ((hold_q == '0) && BasketReq) begin
          state_d = BASKET;
          hold_d  = HOLD_LOAD;
        end
      end
      INTERACTIVE: begin
        if (!InteractiveReq) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      BASKET: begin
        if (!BasketReq) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if ((hold_q == '0) && InteractiveReq) begin
          state_d = INTERACTIVE;
          hold_d  = HOLD_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign ActiveSource = state_q;

`ifdef HIGHLIGHT_BLINK_EN
  localparam int               BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic               blink_init_q;

  // Free-running blink; restarts in the lit phase on any grant change and
  // once right after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      blink_init_q  <= 1'b0;
    end else if (!blink_init_q || (state_d != state_q)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      blink_init_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  assign BlinkPhase = blink_phase_q;
`else
  assign BlinkPhase = 1'b0;
`endif

  // Select the highlight of the currently granted source.
  always_comb begin
    src_data = '0;
    case (state_q)
      BARCODE:     src_data = BarcodeMask;
      INTERACTIVE: src_data = onehot[0];
`ifdef HIGHLIGHT_BLINK_EN
      BASKET:      src_data = onehot[1] & {NUM_PRODUCTS{blink_phase_q}};
`else
      BASKET:      src_data = onehot[1];
`endif
      default:     src_data = '0;
    endcase
  end

  // Staged copy every cycle; visible output only moves at frame start so
  // the VGA never shows a half-updated highlight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      staged_q               <= '0;
      HighlightedProductList <= '0;
    end else begin
      staged_q <= src_data;
      if (FrameStart) HighlightedProductList <= staged_q;
    end
  end

endmodule
